// File: rtl/rdid_pkg.sv
// Shared constants, FSM encoding, ID payload type and opcode bit helper for the RDID SPI sequencer.
package rdid_pkg;

  localparam logic [7:0] RDID_OPCODE   = 8'h9F;
  localparam logic [7:0] RDID_EXP_MAN  = 8'h20;
  localparam logic [7:0] RDID_EXP_TYPE = 8'h20;
  localparam logic [7:0] RDID_EXP_CAP  = 8'h15;

  localparam int unsigned RDID_BITS     = 32;
  localparam int unsigned RDID_CMD_BITS = 8;
  localparam int unsigned RDID_BIT_W    = $clog2(RDID_BITS);
  localparam int unsigned RDID_IDX_W    = RDID_BIT_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } rdid_state_e;

  typedef struct packed {
    logic [7:0] man;
    logic [7:0] mem_type;
    logic [7:0] cap;
  } rdid_id_t;

  // Frame bit idx on MOSI: opcode MSB-first for the first byte, zeros afterwards.
  function automatic logic tx_bit(input logic [RDID_IDX_W-1:0] idx);
    logic [7:0] op;
    op = RDID_OPCODE;
    return (idx < RDID_IDX_W'(RDID_CMD_BITS)) ? op[3'd7 - idx[2:0]] : 1'b0;
  endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// SPI clock divider: emits rise/fall strobes every CLK_DIV cycles while enabled; SPICLK idles low.
module spi_sclk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_tick_c,
  output logic fall_tick_c
);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] cnt;
  logic             tick_c;

  // First strobe fires on the first enabled cycle so SPICLK rises right after setup.
  assign tick_c      = en && (cnt == '0);
  assign rise_tick_c = tick_c && !sclk;
  assign fall_tick_c = tick_c && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick_c) begin
      cnt  <= DIV_W'(CLK_DIV - 1);
      sclk <= !sclk;
    end else begin
      cnt  <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/rdid_spi_ctrl.sv
// RDID (0x9F) SPI mode-0 master for the M25P16: one frame per accepted start, 3 ID bytes captured at done.
// Optional macro RDID_ID_CHECK_EN adds id_ok, set at done when the captured ID equals the expected M25P16 ID.
module rdid_spi_ctrl
  import rdid_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned CS_IDLE  = 5
) (
  input  logic       CCLK,
  input  logic       reset_n,
  input  logic       start,
  input  logic       SPIMISO,
  output logic       SPICLK,
  output logic       SPIMOSI,
  output logic       chip_select,
  output logic       busy,
  output logic       done,
  output logic [7:0] man_id,
  output logic [7:0] mem_type,
  output logic [7:0] mem_cap
`ifdef RDID_ID_CHECK_EN
  ,
  output logic       id_ok
`endif
);
  // HOLD covers the final low half-period plus the chip-select hold time.
  localparam int unsigned HOLD_CYC = CLK_DIV + CS_HOLD;
  localparam int unsigned CNT_MAX  = (CS_SETUP > HOLD_CYC) ? CS_SETUP : HOLD_CYC;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned IDLE_W   = $clog2(CS_IDLE + 1);
  localparam int unsigned RX_W     = RDID_BITS - RDID_CMD_BITS;

  rdid_state_e           state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic [RDID_BIT_W-1:0] bit_cnt;
  logic [IDLE_W-1:0]     idle_cnt;
  logic                  armed;
  logic [RX_W-1:0]       rx_sr;
  rdid_id_t              id_q;

  logic shift_en_c, rise_c, fall_c;
  logic accept_c, setup_last_c, shift_last_c, hold_last_c, gap_last_c;
  logic cs_next_c, busy_next_c, done_next_c, mosi_next_c;

  spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_sclk_div (
    .clk         (CCLK),
    .rst_n       (reset_n),
    .en          (shift_en_c),
    .sclk        (SPICLK),
    .rise_tick_c (rise_c),
    .fall_tick_c (fall_c)
  );

  // armed blocks a start that coincides with the reset-release edge.
  assign shift_en_c   = (state == ST_SHIFT);
  assign accept_c     = (state == ST_IDLE) && start && armed && (idle_cnt >= IDLE_W'(CS_IDLE));
  assign setup_last_c = (cnt == CNT_W'(CS_SETUP - 1));
  assign shift_last_c = fall_c && (bit_cnt == RDID_BIT_W'(RDID_BITS - 1));
  assign hold_last_c  = (cnt == CNT_W'(HOLD_CYC - 1));
  assign gap_last_c   = (idle_cnt >= IDLE_W'(CS_IDLE - 1));

  always_ff @(posedge CCLK or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept_c)     state_next = ST_SETUP;
      ST_SETUP: if (setup_last_c) state_next = ST_SHIFT;
      ST_SHIFT: if (shift_last_c) state_next = ST_HOLD;
      ST_HOLD:  if (hold_last_c)  state_next = ST_GAP;
      ST_GAP:   if (gap_last_c)   state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  // Outputs lag the state by one register, so chip_select falls the cycle after acceptance.
  always_comb begin
    cs_next_c   = 1'b1;
    busy_next_c = 1'b0;
    done_next_c = 1'b0;
    mosi_next_c = 1'b0;
    case (state)
      ST_SETUP: begin
        cs_next_c   = 1'b0;
        busy_next_c = 1'b1;
        mosi_next_c = tx_bit('0);
      end
      ST_SHIFT: begin
        cs_next_c   = 1'b0;
        busy_next_c = 1'b1;
        mosi_next_c = fall_c ? tx_bit(RDID_IDX_W'(bit_cnt) + RDID_IDX_W'(1)) : SPIMOSI;
      end
      ST_HOLD: begin
        cs_next_c   = hold_last_c;
        busy_next_c = !hold_last_c;
        done_next_c = hold_last_c;
      end
      default: ;
    endcase
  end

  // Sequencing counters and MISO capture.
  always_ff @(posedge CCLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      idle_cnt <= IDLE_W'(CS_IDLE);
      armed    <= 1'b0;
      rx_sr    <= '0;
    end else begin
      armed <= 1'b1;
      if ((state_next == state) && ((state == ST_SETUP) || (state == ST_HOLD)))
        cnt <= cnt + CNT_W'(1);
      else
        cnt <= '0;
      if (state != ST_SHIFT)
        bit_cnt <= '0;
      else if (fall_c && !shift_last_c)
        bit_cnt <= bit_cnt + RDID_BIT_W'(1);
      if ((state == ST_HOLD) && hold_last_c)
        idle_cnt <= '0;
      else if (idle_cnt < IDLE_W'(CS_IDLE))
        idle_cnt <= idle_cnt + IDLE_W'(1);
      if (shift_en_c && rise_c && (bit_cnt >= RDID_BIT_W'(RDID_CMD_BITS)))
        rx_sr <= {rx_sr[RX_W-2:0], SPIMISO};
    end
  end

  always_ff @(posedge CCLK or negedge reset_n) begin
    if (!reset_n) begin
      chip_select <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      SPIMOSI     <= 1'b0;
      id_q        <= '0;
    end else begin
      chip_select <= cs_next_c;
      busy        <= busy_next_c;
      done        <= done_next_c;
      SPIMOSI     <= mosi_next_c;
      if (done_next_c) id_q <= rdid_id_t'(rx_sr);
    end
  end

  assign man_id   = id_q.man;
  assign mem_type = id_q.mem_type;
  assign mem_cap  = id_q.cap;

`ifdef RDID_ID_CHECK_EN
  always_ff @(posedge CCLK or negedge reset_n) begin
    if (!reset_n)         id_ok <= 1'b0;
    else if (done_next_c) id_ok <= (rx_sr == {RDID_EXP_MAN, RDID_EXP_TYPE, RDID_EXP_CAP});
  end
`endif

endmodule

// File: tb/tb_rdid_spi_ctrl.sv
// Directed bench for rdid_spi_ctrl with a small M25P16 RDID responder and an expected-ID scoreboard.
// Define RDID_ID_CHECK_EN for both bench and RTL to also cover id_ok.
module tb_rdid_spi_ctrl;

  localparam int unsigned CLK_DIV  = 4;
  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_HOLD  = 2;
  localparam int unsigned CS_IDLE  = 5;
  localparam int          EXP_LAT  = 1 + CS_SETUP + 64 * CLK_DIV + CS_HOLD;
  localparam logic [23:0] ID_M25P16 = 24'h202015;

  logic CCLK    = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;
  logic miso    = 1'b0;
  logic       SPICLK, SPIMOSI, chip_select, busy, done;
  logic [7:0] man_id, mem_type, mem_cap;
`ifdef RDID_ID_CHECK_EN
  logic       id_ok;
`endif

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  // Flash responder state
  logic [23:0] m_id      = ID_M25P16;
  logic [7:0]  m_cmd     = 8'h00;
  logic        m_active  = 1'b0;
  int          m_falls   = 0;
  int          n_rises   = 0;
  logic [31:0] mosi_hist = 32'h0;
  int          n_done    = 0;
  int          sclk_viol = 0;

  rdid_spi_ctrl #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_IDLE (CS_IDLE)
  ) dut (
    .CCLK        (CCLK),
    .reset_n     (reset_n),
    .start       (start),
    .SPIMISO     (miso),
    .SPICLK      (SPICLK),
    .SPIMOSI     (SPIMOSI),
    .chip_select (chip_select),
    .busy        (busy),
    .done        (done),
    .man_id      (man_id),
    .mem_type    (mem_type),
    .mem_cap     (mem_cap)
`ifdef RDID_ID_CHECK_EN
    ,
    .id_ok       (id_ok)
`endif
  );

  always #10 CCLK = ~CCLK;

  // Opcode capture and MOSI history on every SPICLK rise
  always @(posedge SPICLK) begin
    m_cmd     = {m_cmd[6:0], SPIMOSI};
    mosi_hist = {mosi_hist[30:0], SPIMOSI};
    n_rises++;
  end

  // ID bytes shifted out MSB-first on falling edges after the opcode byte
  always @(negedge SPICLK or posedge chip_select) begin
    if (chip_select) begin
      m_falls  = 0;
      m_active = 1'b0;
      miso     = 1'b0;
    end else begin
      m_falls++;
      if (m_falls == 8) m_active = (m_cmd == 8'h9F);
      if (m_active && m_falls >= 8 && m_falls <= 31) miso = m_id[5'(31 - m_falls)];
      else miso = 1'b0;
    end
  end

  always @(negedge CCLK) begin
    if (done) n_done++;
    if (chip_select && SPICLK) sclk_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CCLK);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CCLK);
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, output int lat);
    lat = 0;
    while (lat < budget && done !== 1'b1) begin
      @(negedge CCLK);
      lat++;
    end
  endtask

  task automatic check_ids(input string tag);
    logic [23:0] e;
    check({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hxxxxxx;
    check({tag, "_man_id"},   32'(man_id),   32'(e[23:16]));
    check({tag, "_mem_type"}, 32'(mem_type), 32'(e[15:8]));
    check({tag, "_mem_cap"},  32'(mem_cap),  32'(e[7:0]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int r0;
    int d0;
    int gaps;

    tick(3);
    check("rst_cs",   32'(chip_select), 32'd1);
    check("rst_sclk", 32'(SPICLK),      32'd0);
    check("rst_mosi", 32'(SPIMOSI),     32'd0);
    check("rst_busy", 32'(busy),        32'd0);
    check("rst_done", 32'(done),        32'd0);
    check("rst_ids",  32'({man_id, mem_type, mem_cap}), 32'd0);

    // start coincident with reset release
    reset_n = 1'b1;
    pulse_start();
    tick(3);
    check("rel_start_cs",   32'(chip_select), 32'd1);
    check("rel_start_busy", 32'(busy),        32'd0);

    // Frame 1
    d0 = n_done;
    r0 = n_rises;
    exp_q.push_back(m_id);
    pulse_start();
    run_to_done(400, lat);
    check("f1_latency", 32'(lat),         32'(EXP_LAT));
    check("f1_done",    32'(done),        32'd1);
    check("f1_busy",    32'(busy),        32'd0);
    check("f1_cs_high", 32'(chip_select), 32'd1);
    check_ids("f1");
    check("f1_rises",   32'(n_rises - r0), 32'd32);
    check("f1_mosi",    mosi_hist,         32'h9F00_0000);
`ifdef RDID_ID_CHECK_EN
    check("f1_id_ok",   32'(id_ok),        32'd1);
`endif

    // Start 1 cycle after done: inside the gap, dropped
    pulse_start();
    check("f1_done_pulse", 32'(done), 32'd0);
    tick(1);
    check("gap1_cs",   32'(chip_select), 32'd1);
    check("gap1_busy", 32'(busy),        32'd0);
    tick(3);

    // Start 6 cycles after done: accepted; extra starts mid-frame are dropped
    m_id = 24'hA53C81;
    exp_q.push_back(m_id);
    d0 = n_done;
    r0 = n_rises;
    pulse_start();
    check("gap6_cs_accept_edge", 32'(chip_select), 32'd1);
    tick(1);
    check("gap6_cs",   32'(chip_select), 32'd0);
    check("gap6_busy", 32'(busy),        32'd1);
    check("gap6_mosi", 32'(SPIMOSI),     32'd1);
    lat  = 1;
    gaps = 0;
    while (lat < 400 && done !== 1'b1) begin
      start = (lat == 50 || lat == 200);
      @(negedge CCLK);
      lat++;
      if (lat == 100) check("f2_ids_held", 32'({man_id, mem_type, mem_cap}), 32'(ID_M25P16));
      if (!done && !busy) gaps++;
    end
    start = 1'b0;
    check("f2_latency",   32'(lat),  32'(EXP_LAT));
    check("f2_busy_gaps", 32'(gaps), 32'd0);
    check_ids("f2");
`ifdef RDID_ID_CHECK_EN
    check("f2_id_ok", 32'(id_ok), 32'd0);
`endif
    tick(2);
    check("f2_done_count", 32'(n_done - d0),  32'd1);
    check("f2_rises",      32'(n_rises - r0), 32'd32);
    check("f2_mosi",       mosi_hist,         32'h9F00_0000);

    // Reset around cycle 100 of a frame
    tick(8);
    m_id = ID_M25P16;
    d0 = n_done;
    pulse_start();
    tick(99);
    check("mid_active_busy", 32'(busy), 32'd1);
    #5 reset_n = 1'b0;
    #1;
    check("mid_rst_cs",   32'(chip_select), 32'd1);
    check("mid_rst_sclk", 32'(SPICLK),      32'd0);
    check("mid_rst_busy", 32'(busy),        32'd0);
    check("mid_rst_ids",  32'({man_id, mem_type, mem_cap}), 32'd0);
    @(negedge CCLK);
    reset_n = 1'b1;
    tick(10);
    check("mid_rst_no_done", 32'(n_done - d0), 32'd0);

    // Fresh frame after reset
    exp_q.push_back(m_id);
    pulse_start();
    run_to_done(400, lat);
    check("f3_latency", 32'(lat),         32'(EXP_LAT));
    check("f3_cs_high", 32'(chip_select), 32'd1);
    check_ids("f3");
`ifdef RDID_ID_CHECK_EN
    check("f3_id_ok", 32'(id_ok), 32'd1);

    // Capacity byte 0x16 must clear id_ok
    tick(8);
    m_id = 24'h202016;
    exp_q.push_back(m_id);
    pulse_start();
    run_to_done(400, lat);
    check("f4_latency", 32'(lat), 32'(EXP_LAT));
    check_ids("f4");
    check("f4_id_ok", 32'(id_ok), 32'd0);
`endif

    tick(4);
    check("sclk_low_while_cs_high", 32'(sclk_viol),     32'd0);
    check("sb_drained",             32'(exp_q.size()),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
